// File: rtl/q_arith_arbiter.sv
// q_arith_arbiter: round-robin share of one Q-format add/multiply unit behind a 2-stage pipeline
// Results come back in grant order, tagged with the requester index and an overflow flag.
module q_arith_arbiter #(
  parameter int WIDTH = 32,
  parameter int FBITS = 27,
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           op_i,
  input  logic [N_REQ*WIDTH-1:0]     a_i,
  input  logic [N_REQ*WIDTH-1:0]     b_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
  output logic [WIDTH-1:0]           rsp_y_o,
  output logic                       rsp_ovf_o
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr_q, ptr_d, sel;
  logic found, adv2, accept, grant;
  logic s1_v_q, s1_v_d, s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [IW-1:0] s1_id_q, s1_id_d;
  logic s2_v_q, s2_v_d, s2_ovf_q, s2_ovf_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d, sum;
  logic [IW-1:0] s2_id_q, s2_id_d;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic [WIDTH:0] hi;
  logic ovf_add, ovf_mul;
  // scan downward so the lowest offset from the pointer wins
  always_comb begin
    sel = ptr_q;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_i[(int'(ptr_q) + k) % N_REQ]) begin
        sel = IW'((int'(ptr_q) + k) % N_REQ);
        found = 1'b1;
      end
  end
  assign adv2   = !s2_v_q | rsp_ready_i;
  assign accept = !s1_v_q | adv2;
  assign grant  = rst_n & accept & found;
  assign gnt_o  = grant ? N_REQ'(1) << sel : '0;
  assign ptr_d  = !grant ? ptr_q : int'(sel) == N_REQ - 1 ? '0 : sel + 1'b1;
  assign s1_v_d  = accept ? grant : s1_v_q;
  assign s1_op_d = accept ? op_i[sel] : s1_op_q;
  assign s1_a_d  = accept ? a_i[sel*WIDTH +: WIDTH] : s1_a_q;
  assign s1_b_d  = accept ? b_i[sel*WIDTH +: WIDTH] : s1_b_q;
  assign s1_id_d = accept ? sel : s1_id_q;
  assign sum     = s1_a_q + s1_b_q;
  assign ovf_add = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) & (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
  assign prod    = $signed(s1_a_q) * $signed(s1_b_q);
  assign prod_sh = prod >>> FBITS;
  assign hi      = prod_sh[2*WIDTH-1:WIDTH-1];
  assign ovf_mul = !(&hi | ~|hi);
  assign s2_v_d   = adv2 ? s1_v_q : s2_v_q;
  assign s2_id_d  = adv2 ? s1_id_q : s2_id_q;
  assign s2_y_d   = adv2 ? (s1_op_q ? prod_sh[WIDTH-1:0] : sum) : s2_y_q;
  assign s2_ovf_d = adv2 ? (s1_op_q ? ovf_mul : ovf_add) : s2_ovf_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr_q    <= '0;
      s1_v_q   <= 1'b0;
      s1_op_q  <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_id_q  <= '0;
      s2_y_q   <= '0;
      s2_ovf_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      s1_v_q   <= s1_v_d;
      s1_op_q  <= s1_op_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_id_q  <= s1_id_d;
      s2_v_q   <= s2_v_d;
      s2_id_q  <= s2_id_d;
      s2_y_q   <= s2_y_d;
      s2_ovf_q <= s2_ovf_d;
    end
  assign rsp_valid_o = s2_v_q;
  assign rsp_id_o    = s2_id_q;
  assign rsp_y_o     = s2_y_q;
  assign rsp_ovf_o   = s2_ovf_q;
endmodule

// File: doc/q_arith_arbiter.md
Name: q_arith_arbiter

Overview:
- Shares one Q-format fixed-point arithmetic unit (add or multiply, Q5.27 by default) among N_REQ requesters.
- Round-robin arbitration feeds a 2-stage registered pipeline.
- Each result returns tagged with the requester ID, plus an overflow flag.
- Sits between the algorithm sequencers and the arithmetic datapath, so only one adder/multiplier is instantiated.

Parameters:
- WIDTH, 32, total word width (signed two's complement)
- FBITS, 27, fractional bits
- N_REQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_i  in  N_REQ  per-requester request; must be held with stable operands until granted
- op_i  in  N_REQ  per-requester op: 0 = add, 1 = multiply
- a_i  in  N_REQ*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH]
- b_i  in  N_REQ*WIDTH  operand B, same packing
- gnt_o  out  N_REQ  one-hot grant, combinational; operands consumed at the clock edge ending the cycle
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumer ready
- rsp_id_o  out  clog2(N_REQ)  index of requester owning the result
- rsp_y_o  out  WIDTH  result, Q(WIDTH-FBITS).FBITS
- rsp_ovf_o  out  1  result overflowed and was wrapped

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - stage valids = 0; RR pointer = 0
  - rsp_valid_o = 0, rsp_id_o = 0, rsp_y_o = 0, rsp_ovf_o = 0
  - gnt_o forced to 0 while rst_n=0
  - Reset mid-operation drops all in-flight ops silently; requesters re-request.
- Pipeline:
  - S1 holds registered op, a, b, id.
  - S2 is the output register driving the rsp_* ports.
  - adv2 = !S2.valid | rsp_ready_i
  - adv1 = adv2 (S1 moves to S2 when S2 can accept)
  - accept = !S1.valid | adv1
- Arbitration:
  - If accept and |req_i, grant the first asserted req starting from the RR pointer, wrapping modulo N_REQ.
  - Pointer <= granted index + 1 (mod N_REQ) on each grant; unchanged when there is no grant.
  - At most one gnt bit per cycle; gnt_o = 0 when !accept.
- Latency:
  - Grant in cycle t -> rsp_valid_o high in cycle t+2 if no stall.
  - Throughput 1 op/cycle with rsp_ready_i=1.
- Stall: rsp_valid_o=1 & rsp_ready_i=0 holds S2 and its outputs stable. S1 holds if valid; grants stop once S1 is full.
- Empty/full:
  - S1 empty while S2 stalled still accepts one grant (one-entry skid).
  - A bubble in S1 propagates as S2.valid=0 when S2 advances.
- Arithmetic (computed from S1, registered into S2):
  - add: y = a + b modulo 2^WIDTH. ovf = (sign a == sign b) & (sign y != sign a).
  - mul: p = a*b (2*WIDTH signed); y = p >>> FBITS, low WIDTH bits (truncation toward -inf). ovf = 1 if p>>>FBITS is outside the signed WIDTH range.
- Response handshake:
  - The transfer completes on rsp_valid_o & rsp_ready_i.
  - Results return in grant order; rsp_id_o identifies the requester.
- Simultaneous events:
  - A requester re-asserting in the cycle its result transfers is legal.
  - A request dropped before grant is never served.
  - op_i/a_i/b_i of ungranted requesters are ignored.

Test Plan:
- Reset with rst_n=0 for 2 cycles while req_i=4'b1111 -> gnt_o=0; all rsp_* outputs 0; first grant after release goes to req 0.
- Req 2 only, add, a=0x0A000000 (1.25), b=0x06000000 (0.75), rsp_ready_i=1 -> gnt_o=4'b0100 in cycle t; in t+2 rsp_valid_o=1, rsp_id_o=2, rsp_y_o=0x10000000 (2.0), rsp_ovf_o=0.
- Req 1 mul, a=0x10000000 (2.0), b=0xF4000000 (-1.5) -> rsp_y_o=0xE8000000 (-3.0), rsp_ovf_o=0. Add 0x7FFFFFFF+0x00000001 -> rsp_y_o=0x80000000, rsp_ovf_o=1.
- req_i=4'b1111 held, ready=1 -> grants in order 0,1,2,3,0,…, one per cycle; rsp_id_o follows the same sequence 2 cycles later.
- req_i=4'b1111, rsp_ready_i=0 from first response -> exactly 2 grants issued, then gnt_o=0; rsp_* stable. Ready=1 -> both results drain in order, grants resume with req 2.
- Reset asserted with S1 and S2 full -> next cycle rsp_valid_o=0, RR pointer 0; stale results never appear.
